// File: rtl/demux_credit_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : demux_credit_scheduler
// Purpose  : Credit-gated issue of one record stream to a range-limited
//            dispatch demux, with drain/flush sequencing and error/stall status.
// Revision : 1.0 - initial release
// ============================================================================
module demux_credit_scheduler #(
  parameter int DATA_WIDTH       = 96,
  parameter int NUM_OUTPUT_PORTS = 128,
  parameter int SEL_DIWTH        = 7,
  parameter int CREDIT_DEPTH     = 8,
  parameter int CREDIT_WIDTH     = 4,
  parameter int STALL_WIDTH      = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [DATA_WIDTH-1:0]       src_data_i,
  input  logic [SEL_DIWTH-1:0]        src_dest_i,
  input  logic                        src_valid_i,
  output logic                        src_ready_o,
  input  logic [NUM_OUTPUT_PORTS-1:0] credit_return_i,
  input  logic                        flush_req_i,
  output logic [DATA_WIDTH-1:0]       demux_data_o,
  output logic [SEL_DIWTH-1:0]        demux_sel_o,
  output logic                        demux_valid_o,
  output logic                        flush_done_o,
  output logic                        busy_o,
  output logic                        err_bad_dest_o,
  output logic                        err_credit_ovf_o,
  output logic [STALL_WIDTH-1:0]      stall_cnt_o
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  localparam logic [CREDIT_WIDTH-1:0] c_credit_full = CREDIT_WIDTH'(CREDIT_DEPTH);
  localparam logic [CREDIT_WIDTH-1:0] c_credit_one  = CREDIT_WIDTH'(1);
  localparam logic [STALL_WIDTH-1:0]  c_stall_one   = STALL_WIDTH'(1);

  state_e                    state_q, state_d;
  logic [CREDIT_WIDTH-1:0]   credit_q [NUM_OUTPUT_PORTS];
  logic [CREDIT_WIDTH-1:0]   credit_d [NUM_OUTPUT_PORTS];
  logic [DATA_WIDTH-1:0]     demux_data_q;
  logic [SEL_DIWTH-1:0]      demux_sel_q;
  logic                      demux_valid_q;
  logic                      flush_done_q;
  logic                      err_bad_dest_q;
  logic                      err_credit_ovf_q;
  logic [STALL_WIDTH-1:0]    stall_cnt_q;

  logic                      w_dest_ok;
  logic [CREDIT_WIDTH-1:0]   w_sel_credit;
  logic                      w_src_ready;
  logic                      w_accept;
  logic                      w_issue;
  logic                      w_all_full;
  logic                      w_any_ovf;
  logic                      w_flush_done;

  assign w_dest_ok = (int'(src_dest_i) < NUM_OUTPUT_PORTS);

  // Credit of the addressed port; out-of-range destinations never index the array.
  always_comb begin
    w_sel_credit = '0;
    if (w_dest_ok) begin
      w_sel_credit = credit_q[src_dest_i];
    end
  end

  // Bad destinations are always accepted so they can be dropped; DRAIN blocks input.
  assign w_src_ready = (state_q == ST_RUN) && (!w_dest_ok || (w_sel_credit != '0));
  assign w_accept    = src_valid_i && w_src_ready;
  assign w_issue     = w_accept && w_dest_ok;

  // Per-port credit next state: minus issue, plus return, saturating at full.
  always_comb begin
    w_any_ovf  = 1'b0;
    w_all_full = 1'b1;
    for (int i = 0; i < NUM_OUTPUT_PORTS; i++) begin
      credit_d[i] = credit_q[i];
      if (credit_q[i] != c_credit_full) begin
        w_all_full = 1'b0;
      end
      if (w_issue && (int'(src_dest_i) == i) && !credit_return_i[i]) begin
        credit_d[i] = credit_q[i] - c_credit_one;
      end else if (!(w_issue && (int'(src_dest_i) == i)) && credit_return_i[i]) begin
        if (credit_q[i] == c_credit_full) begin
          w_any_ovf = 1'b1;
        end else begin
          credit_d[i] = credit_q[i] + c_credit_one;
        end
      end
    end
  end

  // RUN/DRAIN next state; leaving DRAIN once every buffer is known empty.
  always_comb begin
    state_d      = state_q;
    w_flush_done = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (flush_req_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_all_full) begin
          state_d      = ST_RUN;
          w_flush_done = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State and credit registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_RUN;
      for (int i = 0; i < NUM_OUTPUT_PORTS; i++) begin
        credit_q[i] <= c_credit_full;
      end
    end else begin
      state_q <= state_d;
      for (int i = 0; i < NUM_OUTPUT_PORTS; i++) begin
        credit_q[i] <= credit_d[i];
      end
    end
  end

  // Demux-facing output stage: payload/select hold when nothing is issued.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      demux_data_q  <= '0;
      demux_sel_q   <= '0;
      demux_valid_q <= 1'b0;
      flush_done_q  <= 1'b0;
    end else begin
      demux_valid_q <= w_issue;
      flush_done_q  <= w_flush_done;
      if (w_issue) begin
        demux_data_q <= src_data_i;
        demux_sel_q  <= src_dest_i;
      end
    end
  end

  // Sticky error flags and saturating RUN-state stall counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_bad_dest_q   <= 1'b0;
      err_credit_ovf_q <= 1'b0;
      stall_cnt_q      <= '0;
    end else begin
      if (w_accept && !w_dest_ok) begin
        err_bad_dest_q <= 1'b1;
      end
      if (w_any_ovf) begin
        err_credit_ovf_q <= 1'b1;
      end
      if ((state_q == ST_RUN) && src_valid_i && !w_src_ready && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + c_stall_one;
      end
    end
  end

  assign src_ready_o      = w_src_ready;
  assign demux_data_o     = demux_data_q;
  assign demux_sel_o      = demux_sel_q;
  assign demux_valid_o    = demux_valid_q;
  assign flush_done_o     = flush_done_q;
  assign busy_o           = (state_q == ST_DRAIN);
  assign err_bad_dest_o   = err_bad_dest_q;
  assign err_credit_ovf_o = err_credit_ovf_q;
  assign stall_cnt_o      = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_demux_credit_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_credit_scheduler
// Purpose  : Directed self-checking bench for demux_credit_scheduler
//            (100 ports so out-of-range destinations are reachable).
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_credit_scheduler;

  localparam int DW = 96;
  localparam int NP = 100;
  localparam int SW = 7;
  localparam int CD = 8;
  localparam int CW = 4;
  localparam int TW = 16;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] src_data;
  logic [SW-1:0] src_dest;
  logic          src_valid;
  logic          src_ready;
  logic [NP-1:0] credit_return;
  logic          flush_req;
  logic [DW-1:0] demux_data;
  logic [SW-1:0] demux_sel;
  logic          demux_valid;
  logic          flush_done;
  logic          busy;
  logic          err_bad_dest;
  logic          err_credit_ovf;
  logic [TW-1:0] stall_cnt;

  int tests = 0;
  int fails = 0;

  demux_credit_scheduler #(
    .DATA_WIDTH      (DW),
    .NUM_OUTPUT_PORTS(NP),
    .SEL_DIWTH       (SW),
    .CREDIT_DEPTH    (CD),
    .CREDIT_WIDTH    (CW),
    .STALL_WIDTH     (TW)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .src_data_i      (src_data),
    .src_dest_i      (src_dest),
    .src_valid_i     (src_valid),
    .src_ready_o     (src_ready),
    .credit_return_i (credit_return),
    .flush_req_i     (flush_req),
    .demux_data_o    (demux_data),
    .demux_sel_o     (demux_sel),
    .demux_valid_o   (demux_valid),
    .flush_done_o    (flush_done),
    .busy_o          (busy),
    .err_bad_dest_o  (err_bad_dest),
    .err_credit_ovf_o(err_credit_ovf),
    .stall_cnt_o     (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int count_full();
    int n = 0;
    for (int i = 0; i < NP; i++) begin
      if (dut.credit_q[i] == CW'(CD)) n++;
    end
    return n;
  endfunction

  initial begin
    rst_n         = 1'b0;
    src_data      = '0;
    src_dest      = '0;
    src_valid     = 1'b0;
    credit_return = '0;
    flush_req     = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_valid", demux_valid, 0);
    chk("rst_sel", demux_sel, 0);
    chk("rst_data", demux_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_errs", {err_bad_dest, err_credit_ovf}, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_credits_full", count_full(), NP);
    rst_n = 1'b1;
    tick();

    // Single record to port 5
    src_valid = 1'b1; src_dest = 7'd5; src_data = 96'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA;
    #1 chk("p5_ready", src_ready, 1);
    tick();
    src_valid = 1'b0;
    chk("p5_valid", demux_valid, 1);
    chk("p5_sel", demux_sel, 5);
    chk("p5_data", demux_data, 96'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA);
    chk("p5_credit", dut.credit_q[5], 7);
    tick();
    chk("idle_valid", demux_valid, 0);
    chk("idle_sel_hold", demux_sel, 5);

    // Eight back-to-back records to port 3 exhaust its credit
    for (int i = 0; i < 8; i++) begin
      src_valid = 1'b1; src_dest = 7'd3; src_data = DW'(i + 16);
      #1 chk("b2b_ready", src_ready, 1);
      tick();
      chk("b2b_valid", demux_valid, 1);
      chk("b2b_data", demux_data, i + 16);
    end
    src_data = DW'(96'h9999);
    #1 chk("p3_empty_ready", src_ready, 0);
    tick(); tick(); tick();
    chk("stall_3", stall_cnt, 3);
    chk("stall_no_valid", demux_valid, 0);
    credit_return[3] = 1'b1;
    #1 chk("ret_cycle_ready", src_ready, 0);
    tick();
    credit_return = '0;
    chk("stall_4", stall_cnt, 4);
    #1 chk("after_ret_ready", src_ready, 1);
    tick();
    src_valid = 1'b0;
    chk("ninth_valid", demux_valid, 1);
    chk("ninth_data", demux_data, 128'h9999);
    chk("stall_hold", stall_cnt, 4);

    // Refill ports 3 and 5
    credit_return[3] = 1'b1; credit_return[5] = 1'b1;
    tick();
    credit_return = '0;
    credit_return[3] = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    credit_return = '0;
    chk("refill_full", count_full(), NP);
    chk("refill_no_ovf", err_credit_ovf, 0);

    // Issue and return on full port 7 in the same cycle
    src_valid = 1'b1; src_dest = 7'd7; src_data = DW'(96'h77);
    credit_return[7] = 1'b1;
    tick();
    src_valid = 1'b0;
    chk("p7_both_credit", dut.credit_q[7], 8);
    chk("p7_both_no_ovf", err_credit_ovf, 0);
    chk("p7_both_sel", demux_sel, 7);
    tick();
    credit_return = '0;
    chk("p7_ovf_flag", err_credit_ovf, 1);
    chk("p7_ovf_credit", dut.credit_q[7], 8);

    // Outstanding on 1,2,2 then flush in the cycle of the last issue
    src_valid = 1'b1; src_dest = 7'd1; tick();
    src_dest = 7'd2; tick();
    flush_req = 1'b1;
    #1 chk("flush_cycle_ready", src_ready, 1);
    tick();
    chk("drain_busy", busy, 1);
    chk("drain_last_valid", demux_valid, 1);
    chk("drain_credit2", dut.credit_q[2], 6);
    src_dest = 7'd9;
    #1 chk("drain_ready", src_ready, 0);
    tick();
    flush_req = 1'b0;
    chk("drain_no_stall", stall_cnt, 4);
    chk("drain_flush_ignored_busy", busy, 1);
    credit_return[1] = 1'b1; tick();
    credit_return = '0; credit_return[2] = 1'b1; tick();
    chk("drain_mid_done", flush_done, 0);
    tick();
    credit_return = '0;
    chk("drain_all_ret_busy", busy, 1);
    chk("drain_all_ret_done", flush_done, 0);
    tick();
    src_valid = 1'b0;
    chk("flush_done_pulse", flush_done, 1);
    chk("flush_busy_low", busy, 0);
    #1 chk("flush_ready_back", src_ready, 1);
    tick();
    chk("flush_done_once", flush_done, 0);

    // Flush with all credits already full
    flush_req = 1'b1; tick();
    flush_req = 1'b0;
    chk("empty_flush_busy", busy, 1);
    tick();
    chk("empty_flush_done", flush_done, 1);
    chk("empty_flush_busy_low", busy, 0);

    // Out-of-range destination
    src_valid = 1'b1; src_dest = 7'd120; src_data = DW'(96'hBAD);
    #1 chk("bad_ready", src_ready, 1);
    tick();
    src_valid = 1'b0;
    chk("bad_no_valid", demux_valid, 0);
    chk("bad_err", err_bad_dest, 1);
    chk("bad_sel_hold", demux_sel, 2);
    chk("bad_credits", count_full(), NP);

    // Asynchronous reset in the middle of DRAIN
    src_valid = 1'b1; src_dest = 7'd4; src_data = DW'(96'h44);
    tick(); tick();
    flush_req = 1'b1; tick();
    src_valid = 1'b0; flush_req = 1'b0;
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_credit4", dut.credit_q[4], 5);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", demux_valid, 0);
    chk("arst_data", demux_data, 0);
    chk("arst_sel", demux_sel, 0);
    chk("arst_busy", busy, 0);
    chk("arst_errs", {err_bad_dest, err_credit_ovf}, 0);
    chk("arst_stall", stall_cnt, 0);
    chk("arst_credits", count_full(), NP);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_done", flush_done, 0);
    #1 chk("post_rst_ready", src_ready, 1);

    // Normal issue after recovery
    src_valid = 1'b1; src_dest = 7'd0; src_data = DW'(96'h123);
    tick();
    src_valid = 1'b0;
    chk("final_valid", demux_valid, 1);
    chk("final_data", demux_data, 128'h123);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
